// File: rtl/sw_debounce2_pkg.sv
// sw_debounce2_pkg: default debounce length and counter width shared by the debouncer files
package sw_debounce2_pkg;
    localparam int DEF_DB_CYCLES = 4;
    localparam int DEF_CNT_W     = 16;
endpackage

// File: rtl/sw_debounce2_db_chan.sv
// db_chan: one switch channel (2-flop synchronizer, debounce counter, debounced level and rise pulse)
module db_chan
    import sw_debounce2_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic x,
    output logic rise,
    output logic tgl
);
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;
    logic             diff, fire;
    assign diff = s2 != x;
    assign fire = diff && cnt == CNT_W'(DB_CYCLES - 1);
    // any agreement between s2 and x restarts the count, so short excursions never accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            x    <= 1'b0;
            rise <= 1'b0;
            tgl  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            cnt  <= (diff && !fire) ? cnt + 1'b1 : '0;
            x    <= fire ? s2 : x;
            rise <= fire & s2;
            tgl  <= fire;
        end
    end
endmodule

// File: rtl/sw_debounce2.sv
// sw_debounce2: two independent debounced switch channels with a shared change pulse
module sw_debounce2
    import sw_debounce2_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic sw1_in,
    input  logic sw2_in,
    output logic x1,
    output logic x2,
    output logic x1_rise,
    output logic x2_rise,
    output logic changed
);
    logic t1, t2;
    db_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch1 (
        .clk  (clk),
        .rst  (rst),
        .raw  (sw1_in),
        .x    (x1),
        .rise (x1_rise),
        .tgl  (t1)
    );
    db_chan #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch2 (
        .clk  (clk),
        .rst  (rst),
        .raw  (sw2_in),
        .x    (x2),
        .rise (x2_rise),
        .tgl  (t2)
    );
    // both toggle pulses are registered in the same cycle, so simultaneous toggles merge into one pulse
    assign changed = t1 | t2;
endmodule
